// File: rtl/ex_commit_stage.sv
// ex_commit_stage
//   Sits between the integer ALU and the memory stage. It resolves branches,
//   JAL and JALR, issues a one-cycle front-end redirect, chooses the
//   writeback value and holds the EX/MEM register under a valid/ready
//   handshake. It also counts resolved and taken conditional branches.
//
// Ports
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready   upstream handshake
//   alu_ctrl, alu_res   one-hot ALU op and its result (bit 0 = branch outcome)
//   in_pc, in_imm       instruction PC and sign-extended immediate
//   in_jal, in_jalr     jump flags (for JALR, alu_res = rs1 + imm)
//   in_rd.. in_wdata    instruction context carried into EX/MEM
//   out_valid/out_ready downstream handshake
//   out_res .. out_pc   EX/MEM register contents
//   redirect_valid/_pc  one-cycle fetch redirect
//   flush               synchronous kill from a later stage
//   br_cnt/br_taken_cnt branch performance counters
module ex_commit_stage #(
   parameter int XLEN   = 64,
   parameter int CTRL_W = 17,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] alu_ctrl,
   input  logic [XLEN-1:0]   alu_res,
   input  logic [XLEN-1:0]   in_pc,
   input  logic [XLEN-1:0]   in_imm,
   input  logic              in_jal,
   input  logic              in_jalr,
   input  logic [4:0]        in_rd,
   input  logic              in_rd_we,
   input  logic              in_mem_re,
   input  logic              in_mem_we,
   input  logic [1:0]        in_mem_size,
   input  logic [XLEN-1:0]   in_wdata,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [XLEN-1:0]   out_res,
   output logic [4:0]        out_rd,
   output logic              out_rd_we,
   output logic              out_mem_re,
   output logic              out_mem_we,
   output logic [1:0]        out_mem_size,
   output logic [XLEN-1:0]   out_wdata,
   output logic [XLEN-1:0]   out_pc,
   output logic              redirect_valid,
   output logic [XLEN-1:0]   redirect_pc,
   input  logic              flush,
   output logic [CNT_W-1:0]  br_cnt,
   output logic [CNT_W-1:0]  br_taken_cnt
);

   typedef enum logic {RUN, SHADOW} state_t;

   state_t          state, state_nxt;
   logic            is_br, br_taken, take, accept;
   logic [XLEN-1:0] target, wb_val;

   // Classification and target/writeback selection
   always_comb begin
      is_br    = |alu_ctrl[16:11];
      br_taken = is_br & alu_res[0];
      take     = br_taken | in_jal | in_jalr;
      target   = in_jalr ? {alu_res[XLEN-1:1], 1'b0} : (in_pc + in_imm);
      wb_val   = (in_jal | in_jalr) ? (in_pc + XLEN'(4)) : alu_res;
   end

   // Nothing is accepted in SHADOW; in_ready there just swallows wrong-path work.
   always_comb accept = in_valid & in_ready & (state == RUN) & ~flush;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= RUN;
      else     state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = RUN;
      if (!flush && state == RUN && accept && take)
         state_nxt = SHADOW;
   end

   // Output logic: the redirect pulse is exactly the SHADOW cycle
   always_comb begin
      redirect_valid = (state == SHADOW);
      in_ready       = ~out_valid | out_ready | (state == SHADOW);
   end

   // EX/MEM valid
   always_ff @(posedge clk or posedge rst) begin
      if (rst)            out_valid <= 1'b0;
      else if (flush)     out_valid <= 1'b0;
      else if (accept)    out_valid <= 1'b1;
      else if (out_ready) out_valid <= 1'b0;
   end

   // EX/MEM payload and redirect target
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_res      <= '0;
         out_rd       <= '0;
         out_rd_we    <= 1'b0;
         out_mem_re   <= 1'b0;
         out_mem_we   <= 1'b0;
         out_mem_size <= '0;
         out_wdata    <= '0;
         out_pc       <= '0;
         redirect_pc  <= '0;
      end else if (accept) begin
         out_res      <= wb_val;
         out_rd       <= in_rd;
         out_rd_we    <= in_rd_we;
         out_mem_re   <= in_mem_re;
         out_mem_we   <= in_mem_we;
         out_mem_size <= in_mem_size;
         out_wdata    <= in_wdata;
         out_pc       <= in_pc;
         if (take) redirect_pc <= target;
      end
   end

   // Branch counters
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         br_cnt       <= '0;
         br_taken_cnt <= '0;
      end else if (accept && is_br) begin
         br_cnt <= br_cnt + CNT_W'(1);
         if (br_taken) br_taken_cnt <= br_taken_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_ex_commit_stage.sv
module tb_ex_commit_stage;

   localparam int XLEN = 64;
   localparam int CTRL_W = 17;
   localparam int CNT_W = 32;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [CTRL_W-1:0] alu_ctrl;
   logic [XLEN-1:0]   alu_res, in_pc, in_imm, in_wdata;
   logic              in_jal, in_jalr, in_rd_we, in_mem_re, in_mem_we;
   logic [4:0]        in_rd;
   logic [1:0]        in_mem_size;
   logic              out_valid, out_ready;
   logic [XLEN-1:0]   out_res, out_wdata, out_pc, redirect_pc;
   logic [4:0]        out_rd;
   logic              out_rd_we, out_mem_re, out_mem_we;
   logic [1:0]        out_mem_size;
   logic              redirect_valid, flush;
   logic [CNT_W-1:0]  br_cnt, br_taken_cnt;

   ex_commit_stage #(.XLEN(XLEN), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .alu_ctrl(alu_ctrl), .alu_res(alu_res), .in_pc(in_pc), .in_imm(in_imm),
      .in_jal(in_jal), .in_jalr(in_jalr), .in_rd(in_rd), .in_rd_we(in_rd_we),
      .in_mem_re(in_mem_re), .in_mem_we(in_mem_we), .in_mem_size(in_mem_size),
      .in_wdata(in_wdata), .out_valid(out_valid), .out_ready(out_ready),
      .out_res(out_res), .out_rd(out_rd), .out_rd_we(out_rd_we),
      .out_mem_re(out_mem_re), .out_mem_we(out_mem_we),
      .out_mem_size(out_mem_size), .out_wdata(out_wdata), .out_pc(out_pc),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .flush(flush), .br_cnt(br_cnt), .br_taken_cnt(br_taken_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [CTRL_W-1:0] ctrl;
      logic [XLEN-1:0]   res;
      logic [XLEN-1:0]   pc;
      logic [XLEN-1:0]   imm;
      logic              jal;
      logic              jalr;
      logic [4:0]        rd;
      logic [XLEN-1:0]   exp_res;
      logic              exp_redir;
      logic [XLEN-1:0]   exp_rpc;
      int                br_inc;
      int                tk_inc;
   } vec_t;

   localparam int NV = 9;
   vec_t vecs [NV];

   int checks = 0;
   int failures = 0;
   int exp_br = 0;
   int exp_tk = 0;

   task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      in_valid = 1'b0; alu_ctrl = '0; alu_res = '0; in_pc = '0; in_imm = '0;
      in_jal = 1'b0; in_jalr = 1'b0; in_rd = '0; in_rd_we = 1'b0;
      in_mem_re = 1'b0; in_mem_we = 1'b0; in_mem_size = '0; in_wdata = '0;
   endtask

   task automatic drive(input logic [CTRL_W-1:0] c, input logic [XLEN-1:0] r,
                        input logic [XLEN-1:0] p, input logic [XLEN-1:0] i,
                        input logic j, input logic jr, input logic [4:0] d);
      in_valid = 1'b1; alu_ctrl = c; alu_res = r; in_pc = p; in_imm = i;
      in_jal = j; in_jalr = jr; in_rd = d; in_rd_we = 1'b1;
   endtask

   task automatic chk_cnt(input string tag);
      chk({tag, "_br_cnt"}, XLEN'(br_cnt), XLEN'(exp_br));
      chk({tag, "_tk_cnt"}, XLEN'(br_taken_cnt), XLEN'(exp_tk));
   endtask

   initial begin
      //         ctrl      res                    pc                     imm                    jal   jalr  rd  exp_res                redir exp_rpc               br tk
      vecs[0] = '{17'h00001, 64'h5,               64'h0,                 64'h0,                 1'b0, 1'b0, 3,  64'h5,                 1'b0, 64'h0,                0, 0};
      vecs[1] = '{17'h00800, 64'h1,               64'h1000,              64'h20,                1'b0, 1'b0, 0,  64'h1,                 1'b1, 64'h1020,             1, 1};
      vecs[2] = '{17'h01000, 64'h0,               64'h1100,              64'h40,                1'b0, 1'b0, 0,  64'h0,                 1'b0, 64'h0,                1, 0};
      vecs[3] = '{17'h00001, 64'h2003,            64'h100,               64'h0,                 1'b0, 1'b1, 1,  64'h104,               1'b1, 64'h2002,             0, 0};
      vecs[4] = '{17'h00001, 64'h0,               64'h3000,              64'hFFFF_FFFF_FFFF_FFF8, 1'b1, 1'b0, 2, 64'h3004,              1'b1, 64'h2FF8,             0, 0};
      vecs[5] = '{17'h10000, 64'h1,               64'h0,                 64'h40,                1'b0, 1'b0, 0,  64'h1,                 1'b1, 64'h40,               1, 1};
      vecs[6] = '{17'h00002, 64'hDEAD_BEEF_0000_0001, 64'h200,           64'h0,                 1'b0, 1'b0, 31, 64'hDEAD_BEEF_0000_0001, 1'b0, 64'h0,               0, 0};
      vecs[7] = '{17'h02000, 64'h2,               64'h300,               64'h8,                 1'b0, 1'b0, 0,  64'h2,                 1'b0, 64'h0,                1, 0};
      vecs[8] = '{17'h00800, 64'h1,               64'hFFFF_FFFF_FFFF_FFF0, 64'h20,              1'b0, 1'b0, 0,  64'h1,                 1'b1, 64'h10,               1, 1};

      idle_inputs();
      out_ready = 1'b1;
      flush = 1'b0;
      rst = 1'b1;
      #1;
      chk("rst_out_valid", XLEN'(out_valid), 0);
      chk("rst_redirect_valid", XLEN'(redirect_valid), 0);
      chk("rst_out_res", out_res, 0);
      chk("rst_redirect_pc", redirect_pc, 0);
      chk_cnt("rst");
      step();
      rst = 1'b0;

      // Table: one instruction, then one idle cycle
      for (int i = 0; i < NV; i++) begin
         drive(vecs[i].ctrl, vecs[i].res, vecs[i].pc, vecs[i].imm, vecs[i].jal, vecs[i].jalr, vecs[i].rd);
         step();
         idle_inputs();
         exp_br += vecs[i].br_inc;
         exp_tk += vecs[i].tk_inc;
         chk($sformatf("v%0d_out_valid", i), XLEN'(out_valid), 1);
         chk($sformatf("v%0d_out_res", i), out_res, vecs[i].exp_res);
         chk($sformatf("v%0d_out_rd", i), XLEN'(out_rd), XLEN'(vecs[i].rd));
         chk($sformatf("v%0d_out_pc", i), out_pc, vecs[i].pc);
         chk($sformatf("v%0d_redirect_valid", i), XLEN'(redirect_valid), XLEN'(vecs[i].exp_redir));
         if (vecs[i].exp_redir) chk($sformatf("v%0d_redirect_pc", i), redirect_pc, vecs[i].exp_rpc);
         chk_cnt($sformatf("v%0d", i));
         step();
         chk($sformatf("v%0d_redirect_gone", i), XLEN'(redirect_valid), 0);
         chk($sformatf("v%0d_drained", i), XLEN'(out_valid), 0);
      end

      // Wrong-path instruction in the SHADOW cycle is dropped
      drive(17'h00800, 64'h1, 64'h500, 64'h10, 1'b0, 1'b0, 0);
      step();
      exp_br++; exp_tk++;
      chk("wp_redirect_valid", XLEN'(redirect_valid), 1);
      chk("wp_redirect_pc", redirect_pc, 64'h510);
      drive(17'h00800, 64'h1, 64'h600, 64'h10, 1'b0, 1'b0, 7);
      chk("wp_in_ready", XLEN'(in_ready), 1);
      step();
      idle_inputs();
      chk("wp_out_valid", XLEN'(out_valid), 0);
      chk("wp_redirect_valid2", XLEN'(redirect_valid), 0);
      chk("wp_out_rd", XLEN'(out_rd), 0);
      chk_cnt("wp");

      // Backpressure: hold for 3 cycles, then capture on the drain edge
      out_ready = 1'b0;
      drive(17'h00001, 64'h11, 64'h700, 64'h0, 1'b0, 1'b0, 4);
      step();
      drive(17'h00001, 64'h22, 64'h704, 64'h0, 1'b0, 1'b0, 5);
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("bp%0d_in_ready", k), XLEN'(in_ready), 0);
         chk($sformatf("bp%0d_out_valid", k), XLEN'(out_valid), 1);
         chk($sformatf("bp%0d_out_res", k), out_res, 64'h11);
         chk($sformatf("bp%0d_out_rd", k), XLEN'(out_rd), 4);
         step();
      end
      out_ready = 1'b1;
      #1;
      chk("bp_in_ready_release", XLEN'(in_ready), 1);
      step();
      idle_inputs();
      chk("bp_swap_out_valid", XLEN'(out_valid), 1);
      chk("bp_swap_out_res", out_res, 64'h22);
      chk("bp_swap_out_rd", XLEN'(out_rd), 5);
      step();
      chk("bp_drained", XLEN'(out_valid), 0);

      // Flush with a taken branch presented
      drive(17'h00800, 64'h1, 64'h800, 64'h40, 1'b0, 1'b0, 9);
      flush = 1'b1;
      step();
      flush = 1'b0;
      idle_inputs();
      chk("fl_out_valid", XLEN'(out_valid), 0);
      chk("fl_redirect_valid", XLEN'(redirect_valid), 0);
      chk_cnt("fl");
      step();
      chk("fl_redirect_valid2", XLEN'(redirect_valid), 0);

      // Flush kills a valid instruction held under backpressure
      out_ready = 1'b0;
      drive(17'h00001, 64'h33, 64'h900, 64'h0, 1'b0, 1'b0, 6);
      step();
      idle_inputs();
      chk("flv_out_valid_pre", XLEN'(out_valid), 1);
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("flv_out_valid", XLEN'(out_valid), 0);
      out_ready = 1'b1;

      // Reset mid-SHADOW clears outputs before the next edge
      drive(17'h00800, 64'h1, 64'hA00, 64'h20, 1'b0, 1'b0, 8);
      step();
      idle_inputs();
      chk("rs_redirect_valid_pre", XLEN'(redirect_valid), 1);
      #2;
      rst = 1'b1;
      #1;
      chk("rs_redirect_valid", XLEN'(redirect_valid), 0);
      chk("rs_out_valid", XLEN'(out_valid), 0);
      chk("rs_redirect_pc", redirect_pc, 0);
      chk("rs_out_res", out_res, 0);
      chk("rs_out_rd", XLEN'(out_rd), 0);
      exp_br = 0; exp_tk = 0;
      chk_cnt("rs");
      step();
      rst = 1'b0;
      step();
      chk("rs_after_redirect", XLEN'(redirect_valid), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ex_commit_stage.md
Name: ex_commit_stage

Overview:
- Pipeline stage directly downstream of the integer ALU. Consumes the ALU result together with the instruction context, and resolves branches, JAL and JALR.
- Generates a registered one-cycle front-end redirect, selects the writeback value, and holds the EX/MEM pipeline register under a valid/ready handshake with the memory stage.
- Also keeps branch performance counters.

Parameters:
- XLEN, 64, datapath width.
- CTRL_W, 17, width of alu_ctrl: one-hot, bit 0 add … bit 16 bgeu; bits 11..16 are the branch ops.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  upstream holds a valid instruction.
- in_ready  out  1  stage can accept this cycle.
- alu_ctrl  in  CTRL_W  one-hot ALU op of the incoming instruction.
- alu_res  in  XLEN  ALU result for the incoming instruction.
- in_pc  in  XLEN  instruction PC.
- in_imm  in  XLEN  sign-extended immediate.
- in_jal  in  1  instruction is JAL.
- in_jalr  in  1  instruction is JALR; alu_res carries rs1+imm.
- in_rd  in  5  destination register.
- in_rd_we  in  1  register write enable.
- in_mem_re  in  1  load.
- in_mem_we  in  1  store.
- in_mem_size  in  2  0=B, 1=H, 2=W, 3=D.
- in_wdata  in  XLEN  store data.
- out_valid  out  1  EX/MEM register holds a valid instruction.
- out_ready  in  1  memory stage accepts.
- out_res  out  XLEN  writeback value, or memory address for loads/stores.
- out_rd  out  5  latched destination register.
- out_rd_we  out  1  latched register write enable.
- out_mem_re  out  1  latched load flag.
- out_mem_we  out  1  latched store flag.
- out_mem_size  out  2  latched access size.
- out_wdata  out  XLEN  latched store data.
- out_pc  out  XLEN  latched PC.
- redirect_valid  out  1  one-cycle pulse: front end must fetch from redirect_pc.
- redirect_pc  out  XLEN  redirect target.
- flush  in  1  synchronous kill from a later stage (trap).
- br_cnt  out  CNT_W  number of resolved conditional branches.
- br_taken_cnt  out  CNT_W  number of taken conditional branches.

Behaviour:
- Reset (async, rst=1): every output register is 0, including out_valid, redirect_valid, both counters and all payload outputs; state = RUN.
- Handshake:
  - in_ready = ~out_valid | out_ready | (state==SHADOW).
  - Accept means in_valid & in_ready & (state==RUN) & ~flush.
  - Payload is captured only on accept. With out_valid=1 and out_ready=0 the payload is held stable.
  - out_valid next value: 1 on accept; else 0 if out_ready; else unchanged.
  - Latency: 1 cycle from accept to out_valid.
- Classification:
  - is_br = |alu_ctrl[16:11].
  - br_taken = is_br & alu_res[0].
  - take = br_taken | in_jal | in_jalr.
- Target: in_jalr → alu_res with bit 0 forced to 0; otherwise in_pc + in_imm, modulo 2^XLEN.
- Writeback value: out_res = in_pc + 4 when in_jal|in_jalr, else alu_res.
- States:
  - RUN: on an accept with take=1, the next cycle has redirect_valid=1, redirect_pc = target, and state goes to SHADOW.
  - SHADOW (exactly one cycle): redirect_valid=1 and in_ready=1. Any in_valid is consumed and discarded (wrong-path shadow): nothing is captured and no counter is updated. Next state is RUN.
- redirect_valid is 1 only in SHADOW, never two consecutive cycles, and a new redirect is never generated from SHADOW.
- Counters:
  - On accept with is_br, br_cnt increments by 1; br_taken_cnt increments by 1 if br_taken.
  - JAL and JALR are not counted.
  - Both counters wrap modulo 2^CNT_W.
- flush=1 has priority over everything:
  - Next cycle out_valid=0, redirect_valid=0, state=RUN.
  - No accept and no counter update in the flush cycle.
  - Payload registers may retain stale values.
- Simultaneous accept and drain (out_valid=1, out_ready=1, accept) replaces the register contents in the same edge with no bubble.
- Reset mid-operation clears any pending redirect and valid instruction immediately, asynchronously.

Test Plan:
- ADD: alu_ctrl=0x00001, alu_res=0x5, rd=3, out_ready=1 → next cycle out_valid=1, out_res=5, out_rd=3, redirect_valid stays 0, counters unchanged.
- Taken BEQ: alu_ctrl=0x00800, alu_res=1, pc=0x1000, imm=0x20 → redirect_valid pulse one cycle with redirect_pc=0x1020. A wrong-path instruction presented in that cycle is dropped (out_valid stays 0 the following cycle). br_cnt=1, br_taken_cnt=1.
- Not-taken BNE: alu_ctrl=0x01000, alu_res=0 → no redirect, br_cnt increments by 1, br_taken_cnt unchanged.
- JALR: alu_res=0x2003, pc=0x100, rd=1 → redirect_pc=0x2002, out_res=0x104, counters unchanged.
- Backpressure: out_ready=0 for 3 cycles with a second instruction valid → in_ready=0, payload stable. On out_ready=1 the second instruction is captured on the same edge as the drain.
- flush with a taken branch presented, and separately rst asserted mid-SHADOW → flush case: no redirect, out_valid=0. Reset case: all outputs 0 asynchronously, before the next clock edge.
